// File: rtl/ram_cmd_bank.sv
// Command-driven register-array RAM: SETADDR/WRITE/READ/CLEAR over a valid/ready port,
// with an internal address pointer, registered read data and a clear sweep after reset.
module ram_cmd_bank #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_SETADDR = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sweep_idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              sweep_last;

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state == S_CLEAR);
    assign accept     = cmd_valid & cmd_ready;
    assign sweep_last = &sweep_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && cmd_op == OP_CLEAR) state_nxt = S_CLEAR;
            S_CLEAR: if (sweep_last) state_nxt = S_IDLE;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Sweep index parks at 0 in IDLE so every sweep starts from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx <= '0;
        end else if (state == S_CLEAR) begin
            sweep_idx <= sweep_idx + ADDR_W'(1);
        end else begin
            sweep_idx <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == S_CLEAR && sweep_last) begin
                ptr <= '0;
            end else if (accept) begin
                case (cmd_op)
                    OP_SETADDR: ptr <= cmd_data[ADDR_W-1:0];
                    OP_WRITE: begin
                        if (AUTO_INC != 0) ptr <= ptr + ADDR_W'(1);
                    end
                    OP_READ: begin
                        rd_data  <= mem[ptr];
                        rd_valid <= 1'b1;
                        if (AUTO_INC != 0) ptr <= ptr + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage has no reset; writes are suppressed while rst is high so a command
    // presented alongside reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[sweep_idx] <= '0;
            end else if (accept && cmd_op == OP_WRITE) begin
                mem[ptr] <= cmd_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_cmd_bank.sv
// Directed bench for ram_cmd_bank: one auto-increment instance and one fixed-pointer instance.
module tb_ram_cmd_bank;

    localparam logic [1:0] OP_SETADDR = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [1:0] ptr;
    logic       busy;

    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [1:0] b_op = 2'b00;
    logic [7:0] b_data = 8'h00;
    logic [7:0] b_rd_data;
    logic       b_rd_valid;
    logic [1:0] b_ptr;
    logic       b_busy;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_cmd_bank #(.DATA_W(8), .ADDR_W(2), .AUTO_INC(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rd_data(rd_data),
        .rd_valid(rd_valid), .ptr(ptr), .busy(busy)
    );

    ram_cmd_bank #(.DATA_W(8), .ADDR_W(2), .AUTO_INC(0)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_data(b_data), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .ptr(b_ptr), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and returns 1 ns after the edge that accepted it.
    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_op    = OP_SETADDR;
        cmd_data  = 8'h00;
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] exp);
        issue(OP_READ, 8'h00);
        check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic sweep_expect(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
            step();
        end
        check({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_ptr0"}, {30'd0, ptr}, 32'd0);
    endtask

    initial begin
        // Reset held two cycles, then the post-reset sweep.
        rst = 1'b1;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_ptr", {30'd0, ptr}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        rst = 1'b0;
        sweep_expect("rst_sweep");

        for (int i = 0; i < 4; i++) rd_expect("post_rst_rd", 8'h00);
        idle();
        step();
        check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
        check("ptr_after_4rd", {30'd0, ptr}, 32'd0);

        // Burst write across the wrap point, then read back.
        issue(OP_SETADDR, 8'h03);
        issue(OP_WRITE, 8'hA1);
        issue(OP_WRITE, 8'hB2);
        issue(OP_WRITE, 8'hC3);
        check("burst_wr_ptr", {30'd0, ptr}, 32'd2);
        issue(OP_SETADDR, 8'h03);
        rd_expect("burst_rd0", 8'hA1);
        rd_expect("burst_rd1", 8'hB2);
        rd_expect("burst_rd2", 8'hC3);
        check("burst_rd_ptr", {30'd0, ptr}, 32'd2);
        idle();
        step();
        check("rd_data_hold", {24'd0, rd_data}, 32'h0000_00C3);

        // Upper address bits ignored.
        issue(OP_SETADDR, 8'hFD);
        check("setaddr_mask", {30'd0, ptr}, 32'd1);

        // Read-after-write, back to back.
        issue(OP_SETADDR, 8'h01);
        issue(OP_WRITE, 8'h5A);
        issue(OP_SETADDR, 8'h01);
        rd_expect("raw", 8'h5A);

        // CLEAR with a WRITE held pending throughout the sweep.
        issue(OP_SETADDR, 8'h00);
        for (int i = 0; i < 4; i++) issue(OP_WRITE, 8'hFF);
        issue(OP_CLEAR, 8'h00);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = 8'h77;
        sweep_expect("clr_sweep");
        step();
        check("held_wr_ptr", {30'd0, ptr}, 32'd1);
        rd_expect("clr_rd1", 8'h00);
        rd_expect("clr_rd2", 8'h00);
        rd_expect("clr_rd3", 8'h00);
        issue(OP_SETADDR, 8'h00);
        rd_expect("held_wr_rd0", 8'h77);

        // Reset arriving at sweep index 2 restarts the sweep.
        issue(OP_SETADDR, 8'h00);
        for (int i = 0; i < 4; i++) issue(OP_WRITE, 8'h33);
        issue(OP_CLEAR, 8'h00);
        idle();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_expect("midrst_sweep");
        for (int i = 0; i < 4; i++) rd_expect("midrst_rd", 8'h00);
        idle();

        // Fixed-pointer instance.
        check("b_ready", {31'd0, b_ready}, 32'd1);
        b_valid = 1'b1;
        b_op = OP_SETADDR; b_data = 8'h02; step();
        b_op = OP_WRITE;   b_data = 8'h11; step();
        check("b_ptr_wr", {30'd0, b_ptr}, 32'd2);
        b_op = OP_WRITE;   b_data = 8'h22; step();
        b_op = OP_READ;    b_data = 8'h00; step();
        b_valid = 1'b0;
        check("b_rd_valid", {31'd0, b_rd_valid}, 32'd1);
        check("b_rd_data", {24'd0, b_rd_data}, 32'h0000_0022);
        check("b_ptr_rd", {30'd0, b_ptr}, 32'd2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
